// File: rtl/pc_pkg.sv
// ============================================================================
// Module   : pc_pkg
// Brief    : Shared types and default constants for the KGPMini PC stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  // Sequencer life cycle: BOOT for one edge after reset, then RUN until HALT.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  // Which source feeds the PC register on the coming edge.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_SEQ  = 2'd1,
    SEL_BR   = 2'd2,
    SEL_JMP  = 2'd3
  } pc_sel_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_INC   = 32'd4;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// Module   : pc_next_mux
// Brief    : Combinational next-PC / next-state priority selection
//            (halt > jump > branch_taken > sequential; stall freezes all).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_mux
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  pc_state_t          state,
  input  logic               stall,
  input  logic               halt,
  input  logic               jump,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [ADDR_W-1:0]  seq_pc,
  output pc_state_t          next_state,
  output logic [ADDR_W-1:0]  next_pc,
  output pc_sel_t            sel
);

  // Targets are forced onto a word boundary; no misalignment trap exists.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  // Priority decode of the next PC source and the next FSM state.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    sel        = SEL_HOLD;
    case (state)
      BOOT: begin
        next_state = RUN;
      end
      RUN: begin
        if (stall) begin
          sel = SEL_HOLD;
        end else if (halt) begin
          next_state = HALT;
        end else if (jump) begin
          sel     = SEL_JMP;
          next_pc = jump_target & ALIGN_MASK;
        end else if (branch_taken) begin
          sel     = SEL_BR;
          next_pc = branch_target & ALIGN_MASK;
        end else begin
          sel     = SEL_SEQ;
          next_pc = seq_pc;
        end
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

endmodule : pc_next_mux

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program-counter stage: holds the PC, picks the next fetch
//            address, raises fetch_valid / flush / halted.
//            Optional macro PC_SEQ_PERF_CNT_EN adds a saturating
//            redirect_count output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(DEF_PC_INC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_inc,
  output logic              fetch_valid,
  output logic              flush,
  output logic              halted
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       redirect_count
`endif
);

  pc_state_t         state;
  pc_state_t         next_state;
  pc_sel_t           sel;
  logic [ADDR_W-1:0] next_pc;
  logic              flush_q;
  logic              next_flush;

  // Link value; also the sequential candidate (wraps modulo 2^ADDR_W).
  assign pc_plus_inc = pc + PC_INC;

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_next_mux (
    .state         (state),
    .stall         (stall),
    .halt          (halt),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .pc            (pc),
    .seq_pc        (pc_plus_inc),
    .next_state    (next_state),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  // Flush follows any non-sequential decision in RUN (halt, jump, branch);
  // a stalled RUN cycle keeps the previous flush value.
  always_comb begin
    next_flush = 1'b0;
    if (state == RUN) begin
      next_flush = stall ? flush_q : (sel != SEL_SEQ);
    end
  end

  // State, PC and flush registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state   <= next_state;
      pc      <= next_pc;
      flush_q <= next_flush;
    end
  end

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);
  // A stalled cycle must not squash anything downstream.
  assign flush       = flush_q & ~(stall & (state == RUN));

`ifdef PC_SEQ_PERF_CNT_EN
  logic redirect;
  assign redirect = (sel == SEL_JMP) || (sel == SEL_BR);

  // Saturating count of accepted jumps and taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= 32'd0;
    end else if (redirect && (redirect_count != 32'hFFFF_FFFF)) begin
      redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed vector table plus hand sequences for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, halt;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus_inc;
  logic        fetch_valid, flush, halted;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] redirect_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .fetch_valid   (fetch_valid),
    .flush         (flush),
    .halted        (halted)
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    .redirect_count(redirect_count)
`endif
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        halt;
    logic [31:0] pc;
    logic        fl;
    logic        fv;
    logic        hd;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic j,
                              logic [31:0] jt, logic h, logic [31:0] epc,
                              logic efl, logic efv, logic ehd, logic [31:0] ecnt);
    vec_t v;
    v.stall = s;  v.br = b;  v.bt = bt; v.jmp = j; v.jt = jt; v.halt = h;
    v.pc = epc;   v.fl = efl; v.fv = efv; v.hd = ehd; v.cnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic h);
    stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; halt = h;
  endtask

  initial begin
    // Expected outputs are those seen during the cycle the inputs are applied.
    //            stall br bt         jmp jt         halt pc          fl fv hd cnt
    vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0000_0000, 0, 0, 0, 0); // BOOT
    vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0000_0000, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0000_0004, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,   1, 32'h21,  0, 32'h0000_0008, 0, 1, 0, 0); // jump to 0x20
    vecs[4]  = mk(0, 1, 32'h103, 0, 32'h0,   0, 32'h0000_0020, 1, 1, 0, 1); // branch 0x103
    vecs[5]  = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0000_0100, 1, 1, 0, 2);
    vecs[6]  = mk(0, 1, 32'h300, 1, 32'h200, 0, 32'h0000_0104, 0, 1, 0, 2); // jump wins
    vecs[7]  = mk(1, 1, 32'h400, 0, 32'h0,   0, 32'h0000_0200, 0, 1, 0, 3); // stalled
    vecs[8]  = mk(1, 1, 32'h400, 0, 32'h0,   0, 32'h0000_0200, 0, 1, 0, 3);
    vecs[9]  = mk(0, 1, 32'h400, 0, 32'h0,   0, 32'h0000_0200, 1, 1, 0, 3); // stall falls
    vecs[10] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0000_0400, 1, 1, 0, 4);
    vecs[11] = mk(0, 1, 32'h500, 0, 32'h0,   1, 32'h0000_0404, 0, 1, 0, 4); // halt wins
    vecs[12] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0000_0404, 1, 0, 1, 4);
    vecs[13] = mk(0, 0, 32'h0,   1, 32'h600, 0, 32'h0000_0404, 0, 0, 1, 4); // ignored
    vecs[14] = mk(0, 0, 32'h0,   0, 32'h0,   0, 32'h0000_0404, 0, 0, 1, 4);

    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc",          pc,          32'h0);
    check("reset_flush",       32'(flush),  32'h0);
    check("reset_fetch_valid", 32'(fetch_valid), 32'h0);
    check("reset_halted",      32'(halted), 32'h0);
`ifdef PC_SEQ_PERF_CNT_EN
    check("reset_count",       redirect_count, 32'h0);
`endif

    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt, vecs[i].halt);
      @(negedge clk);
      check($sformatf("v%0d_pc", i),          pc,                 vecs[i].pc);
      check($sformatf("v%0d_pc_plus_inc", i), pc_plus_inc,        vecs[i].pc + 32'd4);
      check($sformatf("v%0d_flush", i),       32'(flush),         32'(vecs[i].fl));
      check($sformatf("v%0d_fetch_valid", i), 32'(fetch_valid),   32'(vecs[i].fv));
      check($sformatf("v%0d_halted", i),      32'(halted),        32'(vecs[i].hd));
`ifdef PC_SEQ_PERF_CNT_EN
      check($sformatf("v%0d_count", i),       redirect_count,     vecs[i].cnt);
`endif
      @(posedge clk); #1;
    end

    // Asynchronous reset while halted, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("halt_rst_pc",     pc,          32'h0);
    check("halt_rst_halted", 32'(halted), 32'h0);
    check("halt_rst_fv",     32'(fetch_valid), 32'h0);
`ifdef PC_SEQ_PERF_CNT_EN
    check("halt_rst_count",  redirect_count, 32'h0);
`endif

    // Wrap-around: jump to the last word, then step sequentially.
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    @(posedge clk); #1;                       // BOOT -> RUN
    drive(0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    check("wrap_pc_top",      pc,          32'hFFFF_FFFC);
    check("wrap_pc_plus_inc", pc_plus_inc, 32'h0000_0000);
    @(posedge clk); #1;
    check("wrap_pc_zero",     pc,          32'h0000_0000);
    check("wrap_flush",       32'(flush),  32'h0);

    // Asynchronous reset in the middle of a redirect.
    drive(0, 0, 32'h0, 1, 32'h700, 0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 32'h0, 0);
    check("redir_pc",    pc,         32'h700);
    check("redir_flush", 32'(flush), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("redir_rst_pc",    pc,         32'h0);
    check("redir_rst_flush", 32'(flush), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_sequencer

`default_nettype wire
